ram_rr_arbiter: RTL and testbench

- Two-port round-robin arbiter that shares one single-port synchronous `ram` instance between requester 0 and requester 1.
- Each requester issues read/write commands with a req/gnt handshake.
- The arbiter registers the winning command onto the RAM port and returns read data with a per-requester valid strobe.
- Sits directly in front of `ram`; all RAM pins are driven only by this block.

---
 rtl/ram_rr_arbiter.sv | 93 +++++++++
 tb/tb_ram_rr_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: two-requester round-robin front end for one single-port synchronous RAM.
//
// Ports
//   clk, rst                     clock and synchronous active-high reset
//   req0/we0/addr0/wdata0        requester 0 command (held stable until gnt0)
//   gnt0, rvalid0                requester 0 accept strobe and read-return strobe
//   req1/we1/addr1/wdata1        requester 1 command (held stable until gnt1)
//   gnt1, rvalid1                requester 1 accept strobe and read-return strobe
//   rdata                        shared read-data return, qualified by rvalid0/rvalid1
//   ram_addr/ram_wen/ram_data_in registered command to the RAM
//   ram_data_out                 RAM read data
//
// Timing: a command granted in cycle N appears on the RAM pins in cycle N+1. A read granted in
// cycle N returns with rvalidX high for exactly cycle N+2.
module ram_rr_arbiter #(
   parameter int BIT_SIZE  = 1024,
   parameter int BIT_DEPTH = 8,
   localparam int ADDR_W   = $clog2(BIT_SIZE / BIT_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic                 we0,
   input  logic [ADDR_W-1:0]    addr0,
   input  logic [BIT_DEPTH-1:0] wdata0,
   output logic                 gnt0,
   output logic                 rvalid0,
   input  logic                 req1,
   input  logic                 we1,
   input  logic [ADDR_W-1:0]    addr1,
   input  logic [BIT_DEPTH-1:0] wdata1,
   output logic                 gnt1,
   output logic                 rvalid1,
   output logic [BIT_DEPTH-1:0] rdata,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic                 ram_wen,
   output logic [BIT_DEPTH-1:0] ram_data_in,
   input  logic [BIT_DEPTH-1:0] ram_data_out
);

   logic                 prio_q;     // 0: requester 0 wins a tie, 1: requester 1 wins
   logic                 wen_q;
   logic                 rd_pend_q;  // a read was issued to the RAM last edge
   logic                 rd_id_q;    // which requester owns that read
   logic                 xfer;
   logic                 sel_we;
   logic [ADDR_W-1:0]    sel_addr;
   logic [BIT_DEPTH-1:0] sel_wdata;

   // Arbitration and winner mux
   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      if (!rst) begin
         gnt0 = req0 && (!req1 || !prio_q);
         gnt1 = req1 && (!req0 || prio_q);
      end
      xfer      = gnt0 || gnt1;
      sel_we    = gnt1 ? we1    : we0;
      sel_addr  = gnt1 ? addr1  : addr0;
      sel_wdata = gnt1 ? wdata1 : wdata0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q      <= 1'b0;
         wen_q       <= 1'b0;
         ram_addr    <= '0;
         ram_data_in <= '0;
         rd_pend_q   <= 1'b0;
         rd_id_q     <= 1'b0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         rdata       <= '0;
      end else begin
         if (xfer) begin
            prio_q      <= gnt0;  // loser gets priority next time
            ram_addr    <= sel_addr;
            ram_data_in <= sel_wdata;
         end
         wen_q     <= xfer && sel_we;
         rd_pend_q <= xfer && !sel_we;
         rd_id_q   <= gnt1;
         rvalid0   <= rd_pend_q && !rd_id_q;
         rvalid1   <= rd_pend_q && rd_id_q;
         rdata     <= ram_data_out;
      end
   end

   // Gate the write strobe with reset so a write queued at the reset edge never reaches the RAM.
   assign ram_wen = wen_q && !rst;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter: directed bench for ram_rr_arbiter with a behavioural 128 x 8 RAM.
// The arbiter's ram_addr flop acts as the RAM address register, so the RAM array is read
// combinationally from ram_addr and written on the rising edge when ram_wen is high.
module tb_ram_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, we0, req1, we1;
   logic [6:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] rdata;
   logic [6:0] ram_addr;
   logic       ram_wen;
   logic [7:0] ram_data_in, ram_data_out;

   logic [7:0] mem [128];
   logic [7:0] sb  [128];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_wen) mem[ram_addr] <= ram_data_in;
   assign ram_data_out = mem[ram_addr];

   ram_rr_arbiter #(
      .BIT_SIZE (1024),
      .BIT_DEPTH(8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req0        (req0),
      .we0         (we0),
      .addr0       (addr0),
      .wdata0      (wdata0),
      .gnt0        (gnt0),
      .rvalid0     (rvalid0),
      .req1        (req1),
      .we1         (we1),
      .addr1       (addr1),
      .wdata1      (wdata1),
      .gnt1        (gnt1),
      .rvalid1     (rvalid1),
      .rdata       (rdata),
      .ram_addr    (ram_addr),
      .ram_wen     (ram_wen),
      .ram_data_in (ram_data_in),
      .ram_data_out(ram_data_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   // Advance to just after the next rising edge; inputs set afterwards belong to the new cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req0 = 1'b0;
      req1 = 1'b0;
      rst  = 1'b1;
      tick();
      tick();
      rst  = 1'b0;
   endtask

   // Expected per-cycle values for the contention run: grants from cycle C, returns two later.
   localparam logic [5:0] ExpG0 = 6'b000101;  // bit k = cycle C+k
   localparam logic [5:0] ExpG1 = 6'b001010;
   localparam logic [5:0] ExpV0 = 6'b010100;
   localparam logic [5:0] ExpV1 = 6'b101000;

   initial begin
      logic [5:0] g0, g1, v0, v1;
      g0 = ExpG0; g1 = ExpG1; v0 = ExpV0; v1 = ExpV1;
      rst = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 7'd0; wdata0 = 8'h00;
      req1 = 1'b1; we1 = 1'b0; addr1 = 7'd0; wdata1 = 8'h00;

      // Reset held with both requesting: nothing granted, nothing written, nothing returned.
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         check("rst_quiet", {27'd0, gnt0, gnt1, ram_wen, rvalid0, rvalid1}, 32'd0);
      end
      check("rst_addr", {25'd0, ram_addr}, 32'd0);
      check("rst_rdata", {24'd0, rdata}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("first_grant", {30'd0, gnt0, gnt1}, 32'b10);

      // Single requester: write 5 <= A5, then read it back.
      do_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 7'd5; wdata0 = 8'hA5;
      #1;
      check("wr_gnt0", {30'd0, gnt0, gnt1}, 32'b10);
      tick();
      we0 = 1'b0;
      #1;
      check("rd_gnt0", {30'd0, gnt0, gnt1}, 32'b10);
      check("ram_cmd", {16'd0, ram_wen, ram_addr, ram_data_in}, {16'd0, 1'b1, 7'd5, 8'hA5});
      tick();
      req0 = 1'b0;
      #1;
      check("rd_not_yet", {30'd0, rvalid0, ram_wen}, 32'd0);
      tick();
      #1;
      check("rd_ret", {22'd0, rvalid0, rvalid1, rdata}, {22'd0, 2'b10, 8'hA5});
      tick();
      #1;
      check("rd_one_pulse", {30'd0, rvalid0, rvalid1}, 32'd0);

      // Contention: preload 1 = 11 and 2 = 22 via requester 1, then both read continuously.
      do_reset();
      req1 = 1'b1; we1 = 1'b1; addr1 = 7'd1; wdata1 = 8'h11;
      #1;
      check("pre_gnt1a", {30'd0, gnt0, gnt1}, 32'b01);
      tick();
      addr1 = 7'd2; wdata1 = 8'h22;
      #1;
      check("pre_gnt1b", {30'd0, gnt0, gnt1}, 32'b01);
      tick();
      for (int k = 0; k < 6; k++) begin
         req0 = (k < 4); we0 = 1'b0; addr0 = 7'd1;
         req1 = (k < 4); we1 = 1'b0; addr1 = 7'd2;
         #1;
         check("alt_gnt", {30'd0, gnt0, gnt1}, {30'd0, g0[k], g1[k]});
         check("alt_rv", {30'd0, rvalid0, rvalid1}, {30'd0, v0[k], v1[k]});
         if (v0[k]) check("alt_rd0", {24'd0, rdata}, 32'h11);
         if (v1[k]) check("alt_rd1", {24'd0, rdata}, 32'h22);
         tick();
      end

      // Full sweep: requester 1 fills the RAM, requester 0 reads everything back-to-back.
      do_reset();
      for (int i = 0; i < 128; i++) begin
         sb[i] = 8'($urandom);
         req1 = 1'b1; we1 = 1'b1; addr1 = 7'(i); wdata1 = sb[i];
         #1;
         check("sweep_wgnt", {31'd0, gnt1}, 32'd1);
         tick();
      end
      req1 = 1'b0;
      for (int i = 0; i < 130; i++) begin
         req0 = (i < 128); we0 = 1'b0; addr0 = 7'(i);
         #1;
         if (i < 128) check("sweep_rgnt", {31'd0, gnt0}, 32'd1);
         if (i < 2) check("sweep_rv_idle", {30'd0, rvalid0, rvalid1}, 32'd0);
         else check("sweep_rd", {22'd0, rvalid0, rvalid1, rdata}, {22'd0, 2'b10, sb[i-2]});
         tick();
      end
      #1;
      check("sweep_end", {30'd0, rvalid0, rvalid1}, 32'd0);

      // Read-after-write on consecutive grants.
      req1 = 1'b1; we1 = 1'b1; addr1 = 7'd127; wdata1 = 8'h3C;
      #1;
      check("raw_wgnt", {30'd0, gnt0, gnt1}, 32'b01);
      tick();
      req1 = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 7'd127;
      #1;
      check("raw_rgnt", {30'd0, gnt0, gnt1}, 32'b10);
      tick();
      req0 = 1'b0;
      #1;
      check("raw_wait", {31'd0, rvalid0}, 32'd0);
      tick();
      #1;
      check("raw_rd", {23'd0, rvalid0, rdata}, {23'd0, 1'b1, 8'h3C});
      sb[127] = 8'h3C;

      // Reset mid-read: the read in flight is dropped and priority returns to requester 0.
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 7'd5;
      #1;
      check("mr_gnt_a", {31'd0, gnt0}, 32'd1);
      tick();
      addr0 = 7'd6;
      #1;
      check("mr_gnt_b", {31'd0, gnt0}, 32'd1);
      tick();
      req0 = 1'b0;
      rst  = 1'b1;
      #1;
      check("mr_rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
      tick();
      rst  = 1'b0;
      req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 7'd3;
      #1;
      check("mr_dropped", {30'd0, rvalid0, rvalid1}, 32'd0);
      check("mr_prio", {30'd0, gnt0, gnt1}, 32'b10);
      tick();

      // Reset right after a write grant: the write must not reach the RAM.
      req1 = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 7'd9; wdata0 = ~sb[9];
      #1;
      check("wa_gnt", {31'd0, gnt0}, 32'd1);
      tick();
      req0 = 1'b0;
      rst  = 1'b1;
      #1;
      check("wa_wen_off", {31'd0, ram_wen}, 32'd0);
      tick();
      rst  = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 7'd9;
      #1;
      check("wa_rgnt", {30'd0, gnt0, gnt1}, 32'b10);
      tick();
      req0 = 1'b0;
      tick();
      #1;
      check("wa_rd", {23'd0, rvalid0, rdata}, {23'd0, 1'b1, sb[9]});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
